// File: rtl/rf_write_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rf_write_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wn;
    logic [DATA_W-1:0]     wd;
  } wb_entry_t;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Writeback handshake, register-file write port and forwarding lookup bundle.
// Latency: n/a (wires only).
// Backpressure: wb_ready driven by the controller (slave side).
// Ports: wb_* = MEM/WB producer, RegWrite/WN/WD = RF write port, rn*/fwd* = decode lookup.
interface rf_write_ctrl_if;
  import rf_write_ctrl_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_wn;
  logic [DATA_W-1:0]     wb_wd;

  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WN;
  logic [DATA_W-1:0]     WD;
  logic                  busy;

  logic [REG_ADDR_W-1:0] rn1;
  logic [REG_ADDR_W-1:0] rn2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [DATA_W-1:0]     fwd1_data;
  logic [DATA_W-1:0]     fwd2_data;

  modport master (
    output wb_valid, wb_wn, wb_wd, rn1, rn2,
    input  wb_ready, RegWrite, WN, WD, busy,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

  modport slave (
    input  wb_valid, wb_wn, wb_wd, rn1, rn2,
    output wb_ready, RegWrite, WN, WD, busy,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback entries exposing every slot for forwarding compares.
// Latency: a push is visible at head/entries the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: push/push_dat in, pop in, head/full/empty out, entries/valid/rd_ptr out for lookup.
module rf_wb_fifo
  import rf_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_dat,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PTR_W-1:0] rd_ptr
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] off;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head    = mem[rd_ptr_q];
  assign entries = mem;
  assign rd_ptr  = rd_ptr_q;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off      = PTR_W'(j) - rd_ptr_q;
      valid[j] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: post-reset zeroing, writeback FIFO drain, forwarding lookup.
// Latency: accept at edge k -> RegWrite/WN/WD driven during cycle k+1 -> RF captures at k+2.
// Backpressure: wb_ready = RUN && !full; no pass-through when full, even on a same-cycle pop.
// Ports: clk, rst (async, active high); bus = rf_write_ctrl_if.slave.
module rf_write_ctrl
  import rf_write_ctrl_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst,
  rf_write_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [REG_ADDR_W:0] CLR_END = NUM_REGS[REG_ADDR_W:0];
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t                state;
  logic [REG_ADDR_W:0]   clr_cnt;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] wn_q;
  logic [DATA_W-1:0]     wd_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  wb_entry_t             push_dat;
  wb_entry_t             fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  wb_entry_t             fifo_ent [DEPTH];
  logic [DEPTH-1:0]      fifo_valid;
  logic [PTR_W-1:0]      fifo_rd_ptr;
  logic [PTR_W-1:0]      idx;

  // Gated by rst so the handshake is closed while reset is held, even with CLEAR skipped.
  assign bus.wb_ready = !rst && (state == RUN) && !fifo_full;
  // Writes to $zero complete the handshake but are dropped here.
  assign fifo_push    = bus.wb_valid && bus.wb_ready && (bus.wb_wn != '0);
  assign fifo_pop     = (state == RUN) && !fifo_empty;
  assign push_dat     = '{wn: bus.wb_wn, wd: bus.wb_wd};

  rf_wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .entries  (fifo_ent),
    .valid    (fifo_valid),
    .rd_ptr   (fifo_rd_ptr)
  );

  // CLEAR drives WN=1..31 on consecutive cycles and leaves on the edge after WN=31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_STATE;
      clr_cnt     <= (REG_ADDR_W+1)'(1);
      reg_write_q <= 1'b0;
      wn_q        <= '0;
      wd_q        <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == CLR_END) begin
            state       <= RUN;
            reg_write_q <= 1'b0;
          end else begin
            reg_write_q <= 1'b1;
            wn_q        <= clr_cnt[REG_ADDR_W-1:0];
            wd_q        <= '0;
            clr_cnt     <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (fifo_pop) begin
            reg_write_q <= 1'b1;
            wn_q        <= fifo_head.wn;
            wd_q        <= fifo_head.wd;
          end else begin
            reg_write_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.RegWrite = reg_write_q;
  assign bus.WN       = wn_q;
  assign bus.WD       = wd_q;
  assign bus.busy     = (state == CLEAR) || !fifo_empty || reg_write_q;

  // Oldest candidate first so younger matches overwrite: output stage, then head .. tail.
  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
    idx           = '0;
    if (state == RUN) begin
      if (reg_write_q && (wn_q == bus.rn1) && (bus.rn1 != '0)) begin
        bus.fwd1_hit  = 1'b1;
        bus.fwd1_data = wd_q;
      end
      if (reg_write_q && (wn_q == bus.rn2) && (bus.rn2 != '0)) begin
        bus.fwd2_hit  = 1'b1;
        bus.fwd2_data = wd_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = fifo_rd_ptr + PTR_W'(i);
        if (fifo_valid[idx] && (fifo_ent[idx].wn == bus.rn1) && (bus.rn1 != '0)) begin
          bus.fwd1_hit  = 1'b1;
          bus.fwd1_data = fifo_ent[idx].wd;
        end
        if (fifo_valid[idx] && (fifo_ent[idx].wn == bus.rn2) && (bus.rn2 != '0)) begin
          bus.fwd2_hit  = 1'b1;
          bus.fwd2_data = fifo_ent[idx].wd;
        end
      end
    end
  end

endmodule
